// File: rtl/scene_mem_pkg.sv
// scene_mem_pkg: shared word type, idle read value and scene layout offsets.
package scene_mem_pkg;
  typedef logic [15:0] word_t;
  localparam word_t IDLE_DATA = 16'hBEEF;
  localparam int RAY_OFS = 0;
  localparam int RAY_WORDS = 12;
  localparam int NTRIS_OFS = 12;
  localparam int NTRIS_WORDS = 2;
  localparam int TRI_OFS = 14;
  localparam int TRI_WORDS = 18;
endpackage

// File: rtl/rd_latency_pipe.sv
// rd_latency_pipe: DEPTH-stage {valid, data} shift register with async active-low clear.
import scene_mem_pkg::*;
module rd_latency_pipe #(
  parameter int DEPTH = 2
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  in_valid,
  input  word_t in_data,
  output logic  out_valid,
  output word_t out_data
);
  logic [DEPTH-1:0] vld_q, vld_d;
  word_t dat_q [DEPTH];
  word_t dat_d [DEPTH];
  always_comb begin
    vld_d[0] = in_valid;
    dat_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      vld_q <= '0;
      dat_q <= '{default: IDLE_DATA};
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = dat_q[DEPTH-1];
endmodule

// File: rtl/scene_mem_responder.sv
// scene_mem_responder: Avalon-MM 16-bit scene memory with fixed-latency pipelined reads.
// Defining SCENE_MEM_STALL_EN adds one waitrequest cycle every STALL_PERIOD cycles.
import scene_mem_pkg::*;
module scene_mem_responder #(
  parameter int          DEPTH        = 4096,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          READ_LATENCY = 2,
  parameter int          STALL_PERIOD = 7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] avs_s0_address,
  input  logic        avs_s0_read,
  input  logic        avs_s0_write,
  input  logic [15:0] avs_s0_writedata,
  input  logic [1:0]  avs_s0_byteenable,
  output logic [15:0] avs_s0_readdata,
  output logic        avs_s0_readdatavalid,
  output logic        avs_s0_waitrequest,
  output logic        o_err
);
  localparam int AW = $clog2(DEPTH);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || READ_LATENCY < 1 || READ_LATENCY > 8 || STALL_PERIOD < 2)
    begin : g_bad_param
      $error("scene_mem_responder: illegal parameter");
    end
  word_t mem [DEPTH] = '{default: IDLE_DATA};
  logic [31:0] off;
  logic [AW-1:0] idx;
  logic in_range, accept, rd_acc, wr_en, err_q, err_d, pipe_vld;
  word_t rd_word, wr_word, pipe_dat;
  always_comb begin
    off      = avs_s0_address - BASE_ADDR;
    idx      = off[AW:1];
    in_range = (off[31:1] < 31'(DEPTH)) && !off[0];
    accept   = (avs_s0_read || avs_s0_write) && !avs_s0_waitrequest;
    rd_acc   = accept && avs_s0_read;
    wr_en    = accept && avs_s0_write && !avs_s0_read && in_range;
    rd_word  = in_range ? mem[idx] : IDLE_DATA;
    wr_word  = {avs_s0_byteenable[1] ? avs_s0_writedata[15:8] : mem[idx][15:8],
                avs_s0_byteenable[0] ? avs_s0_writedata[7:0]  : mem[idx][7:0]};
    // a simultaneous read+write serves the read and flags the dropped write
    err_d    = err_q | (accept && ((avs_s0_read && avs_s0_write) || !in_range));
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) err_q <= 1'b0;
    else err_q <= err_d;
  always_ff @(posedge clk)
    if (wr_en) mem[idx] <= wr_word;
  rd_latency_pipe #(.DEPTH(READ_LATENCY)) u_pipe (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (rd_acc),
    .in_data  (rd_word),
    .out_valid(pipe_vld),
    .out_data (pipe_dat)
  );
  assign avs_s0_readdata      = pipe_vld ? pipe_dat : IDLE_DATA;
  assign avs_s0_readdatavalid = pipe_vld;
  assign o_err                = err_q;
`ifdef SCENE_MEM_STALL_EN
  localparam int CW = $clog2(STALL_PERIOD);
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  always_comb begin
    stall_cnt_d = (stall_cnt_q == CW'(STALL_PERIOD - 1)) ? '0 : stall_cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) stall_cnt_q <= '0;
    else stall_cnt_q <= stall_cnt_d;
  assign avs_s0_waitrequest = stall_cnt_q == CW'(STALL_PERIOD - 1);
`else
  assign avs_s0_waitrequest = 1'b0;
`endif
endmodule

// File: doc/scene_mem_responder.md
# scene_mem_responder

- Avalon-MM responder (slave) holding scene data: ray words, triangle count and triangle vertex words.
- Serves the `ray_tracer` 16-bit read master with fixed, pipelined read latency.
- Host and bench load it through write transfers on the same port.
- Replaces the behavioural memory model in simulation and backs the ray tracer on-chip in synthesis builds.

## Interface

Parameters:
- `DEPTH`, 4096: number of 16-bit words stored; must be a power of two.
- `BASE_ADDR`, 32'h0000_1000: byte address of word 0.
- `READ_LATENCY`, 2: cycles from read acceptance to `readdatavalid`; legal range 1..8.
- `STALL_PERIOD`, 7: waitrequest insertion period; used only when `SCENE_MEM_STALL_EN` is defined.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `avs_s0_address` in 32: byte address.
- `avs_s0_read` in 1: read request.
- `avs_s0_write` in 1: write request.
- `avs_s0_writedata` in 16: write data.
- `avs_s0_byteenable` in 2: write byte lanes; bit 0 selects [7:0].
- `avs_s0_readdata` out 16: read data.
- `avs_s0_readdatavalid` out 1: read data valid.
- `avs_s0_waitrequest` out 1: command not accepted this cycle.
- `o_err` out 1: sticky error flag.

## Operation

- Command acceptance: a command is accepted on a rising edge where (`read` or `write`) and not `waitrequest`.
- Word index is (`address` − `BASE_ADDR`) >> 1.
- An address is in range when the result is below `DEPTH` and `address[0]` = 0.
- Accepted write, in range: each enabled byte lane is updated. `byteenable` = 0 is a legal no-op.
- Accepted write, out of range: dropped; `o_err` is set.
- Accepted read, in range: returns the word through the latency pipe.
- Accepted read, out of range or misaligned: still returns exactly one beat, with data 16'hBEEF; `o_err` is set.
- `read` and `write` both high on the same edge: the read is performed and the write is dropped; `o_err` is set.
- Reads may issue back-to-back every cycle. Up to `READ_LATENCY` reads are in flight, and responses return in order.
- `o_err` clears only on reset.
- Memory contents are not reset. Simulation initial value is 16'hBEEF.

## Timing

- Reset values: `readdata` = 16'hBEEF, `readdatavalid` = 0, `waitrequest` = 0, `o_err` = 0. Reset clears the stall counter.
- Read accepted at edge N: `readdatavalid` = 1 with data in the cycle after edge N+`READ_LATENCY`−1.
- With `READ_LATENCY` = 2, data is presented for edge N+2 and is sampled by the master at edge N+2.
- `readdata` returns to 16'hBEEF in any cycle where `readdatavalid` = 0.
- Write accepted at edge N is visible to a read accepted at edge N+1 or later. No same-edge bypass.
- Reset asserted mid-operation: in-flight reads are discarded, and no `readdatavalid` is produced for them after reset release.
- Without the stall macro, `waitrequest` is constant 0.

## Configuration

- `SCENE_MEM_STALL_EN`:
  - Defined: a free-running counter (0..`STALL_PERIOD`−1) asserts `waitrequest` combinationally whenever the count equals `STALL_PERIOD`−1. This gives one stall cycle per period; the counter advances every cycle regardless of traffic.
  - A command held during a stall is accepted on the next non-stall edge. The master must hold its command signals while stalled.
  - Undefined: no counter is built and `waitrequest` is tied to 0.

## Structure

- `scene_mem_pkg` holds:
  - `word_t` (logic [15:0]).
  - `IDLE_DATA` = 16'hBEEF.
  - Scene layout offsets, in words: `RAY_OFS` = 0 (12 words), `NTRIS_OFS` = 12 (2 words), `TRI_OFS` = 14 (18 words per triangle).
- Sub-module `rd_latency_pipe`:
  - Shift register of depth `READ_LATENCY` carrying {valid, data}.
  - Parameterised by depth.
  - Async active-low clear.
- Top-level contents: storage array, address decode, byteenable merge, error logic, optional stall counter.

## Test plan

- Load 12 ray words {0,0,0,0,0x0000,0x0001,0,0,0,0,0x0000,0xFFFF} at `BASE_ADDR`, then read them back-to-back.
  - Required: 12 consecutive valid beats in the same order, first beat 2 cycles after the first acceptance, `o_err` stays 0.
- Write 0xAAAA to word 3, then write 0x5500 with `byteenable` = 2'b10, then read word 3.
  - Required: 0x55AA.
- Read at `BASE_ADDR`−2, at `BASE_ADDR`+2·`DEPTH`, and at `BASE_ADDR`+1.
  - Required: three beats of 0xBEEF and `o_err` = 1.
- Assert read and write together to word 0, holding 0x1234, with write data 0xFFFF.
  - Required: readdata 0x1234, word unchanged, `o_err` = 1.
- Issue 2 reads, then assert `reset_n` low for 1 cycle before either returns.
  - Required: no `readdatavalid` after release; `readdata` = 0xBEEF.
- With `SCENE_MEM_STALL_EN` and `STALL_PERIOD` = 7, run 20 back-to-back reads.
  - Required: `waitrequest` high every 7th cycle, all 20 beats returned in order, total span of 23 edges.
